note_sequencer: RTL and testbench

Parametrised successor to the single-note audio controller. It accepts tone/duration pairs through a valid/ready queue and plays them back-to-back with exact timing. An optional silent articulation gap separates notes, and an abort input flushes the queue. It sits between the front-panel or command source and the tone generator, and drives the same TONE/DURATION codes to the tone generator and display.

---
 rtl/audio_pkg.sv | 27 ++
 rtl/note_sequencer_if.sv | 24 ++
 rtl/note_fifo.sv | 64 ++++++
 rtl/note_sequencer.sv | 122 ++++++++++++
 tb/tb_note_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared note-timing constants, FSM encoding and duration decode
package audio_pkg;
    localparam int UNITS_PER_WHOLE = 32;
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
    function automatic logic [6:0] dur_units(input logic [3:0] code);
        logic [6:0] u;
        case (code)
            4'h0: u = 7'd0;
            4'h1: u = 7'd4;
            4'h2: u = 7'd8;
            4'h3: u = 7'd12;
            4'h4: u = 7'd16;
            4'h5: u = 7'd24;
            4'h6: u = 7'd32;
            4'h7: u = 7'd64;
            4'h8: u = 7'd1;
            4'h9: u = 7'd3;
            4'hA: u = 7'd7;
            4'hB: u = 7'd11;
            4'hC: u = 7'd15;
            4'hD: u = 7'd23;
            4'hE: u = 7'd31;
            default: u = 7'd63;
        endcase
        return u;
    endfunction
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: note push handshake plus playback outputs toward the tone generator
interface note_sequencer_if #(
    parameter int TONE_W = 4,
    parameter int DEPTH = 8
);
    logic                       IN_VALID;
    logic                       IN_READY;
    logic [TONE_W-1:0]          IN_TONE;
    logic [3:0]                 IN_DUR;
    logic                       ABORT;
    logic [TONE_W-1:0]          TONE;
    logic [3:0]                 DURATION;
    logic                       BUSY;
    logic                       NOTE_DONE;
    logic [$clog2(DEPTH):0]     COUNT;
    modport master (
        output IN_VALID, IN_TONE, IN_DUR, ABORT,
        input  IN_READY, TONE, DURATION, BUSY, NOTE_DONE, COUNT
    );
    modport slave (
        input  IN_VALID, IN_TONE, IN_DUR, ABORT,
        output IN_READY, TONE, DURATION, BUSY, NOTE_DONE, COUNT
    );
endinterface

// File: rtl/note_fifo.sv
// note_fifo: flushable synchronous FIFO holding queued tone/duration pairs
module note_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          do_push, do_pop;

    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];
    assign count   = cnt_q;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + AW'(1);
            end
            if (do_pop) rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays queued tone/duration pairs back-to-back with optional silent gap
module note_sequencer
    import audio_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int TONE_W = 4,
    parameter int DEPTH = 8,
    parameter int GAP_CYC = 0
) (
    input logic CLK,
    input logic RST,
    note_sequencer_if.slave bus
);
    localparam int U  = CLK_HZ / UNITS_PER_WHOLE;
    localparam int PW = U > 1 ? $clog2(U) : 1;
    localparam int GW = GAP_CYC > 0 ? $clog2(GAP_CYC + 1) : 1;
    localparam int GAP_LAST = GAP_CYC > 0 ? GAP_CYC - 1 : 0;

    state_t              state_q, state_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [6:0]          units_q, units_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [TONE_W-1:0]   tone_q, tone_d;
    logic [3:0]          dur_q, dur_d;
    logic                done_q, done_d;
    logic [TONE_W+3:0]   head;
    logic [TONE_W-1:0]   head_tone;
    logic [3:0]          head_dur;
    logic [6:0]          head_units;
    logic                full, empty, push, wrap, play_end, gap_end, load;

    note_fifo #(.W(TONE_W + 4), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .flush (bus.ABORT),
        .push  (push),
        .pop   (load),
        .din   ({bus.IN_TONE, bus.IN_DUR}),
        .dout  (head),
        .count (bus.COUNT),
        .full  (full),
        .empty (empty)
    );

    assign bus.IN_READY = !full && !bus.ABORT;
    assign push         = bus.IN_VALID && bus.IN_READY;
    assign head_tone    = head[TONE_W+3:4];
    assign head_dur     = head[3:0];
    assign head_units   = dur_units(head_dur);
    assign wrap         = pre_q == PW'(U - 1);
    assign play_end     = state_q == S_PLAY && wrap && units_q == 7'd1;
    assign gap_end      = state_q == S_GAP && gap_q == GW'(GAP_LAST);
    // a new note is taken from idle, after the gap, or straight off the last unit when legato
    assign load = !bus.ABORT && !empty &&
                  (state_q == S_IDLE || gap_end || (play_end && GAP_CYC == 0));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            units_q <= '0;
            gap_q   <= '0;
            tone_q  <= '0;
            dur_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            units_q <= units_d;
            gap_q   <= gap_d;
            tone_q  <= tone_d;
            dur_q   <= dur_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        units_d = units_q;
        gap_d   = '0;
        if (bus.ABORT) begin
            state_d = S_IDLE;
            pre_d   = '0;
            units_d = '0;
        end else if (load) begin
            state_d = head_units != 7'd0 ? S_PLAY : S_IDLE;
            pre_d   = '0;
            units_d = head_units;
        end else if (state_q == S_PLAY) begin
            pre_d   = wrap ? '0 : pre_q + PW'(1);
            units_d = wrap ? units_q - 7'd1 : units_q;
            if (play_end) state_d = GAP_CYC > 0 ? S_GAP : S_IDLE;
        end else if (state_q == S_GAP) begin
            gap_d = gap_end ? '0 : gap_q + GW'(1);
            if (gap_end) state_d = S_IDLE;
        end
    end

    always_comb begin
        tone_d = tone_q;
        dur_d  = dur_q;
        done_d = 1'b0;
        if (bus.ABORT) begin
            tone_d = '0;
            dur_d  = '0;
        end else if (load) begin
            tone_d = head_units != 7'd0 ? head_tone : '0;
            dur_d  = head_units != 7'd0 ? head_dur : 4'd0;
            done_d = play_end || head_units == 7'd0;
        end else if (play_end) begin
            tone_d = '0;
            dur_d  = '0;
            done_d = 1'b1;
        end
    end

    assign bus.TONE      = tone_q;
    assign bus.DURATION  = dur_q;
    assign bus.NOTE_DONE = done_q;
    assign bus.BUSY      = state_q != S_IDLE || !empty;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench comparing played notes against a note-length model
module tb_note_sequencer;
    localparam int CLK_HZ = 320;
    localparam int U = 10;
    localparam int DEPTH = 4;
    localparam int GAP = 3;

    typedef struct {
        int tone;
        int dur;
        int len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic leg_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    int   unit_tbl[16] = '{0, 4, 8, 12, 16, 24, 32, 64, 1, 3, 7, 11, 15, 23, 31, 63};
    int   md[100];
    int   ld[100];
    int   lt[100];

    always #5 clk = ~clk;

    note_sequencer_if #(.TONE_W(4), .DEPTH(DEPTH)) m_if ();
    note_sequencer_if #(.TONE_W(4), .DEPTH(DEPTH)) l_if ();

    note_sequencer #(.CLK_HZ(CLK_HZ), .TONE_W(4), .DEPTH(DEPTH), .GAP_CYC(GAP)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (m_if.slave)
    );

    note_sequencer #(.CLK_HZ(CLK_HZ), .TONE_W(4), .DEPTH(DEPTH), .GAP_CYC(0)) leg (
        .CLK (clk),
        .RST (rst),
        .bus (l_if.slave)
    );

    assign l_if.IN_VALID = leg_en && m_if.IN_VALID;
    assign l_if.IN_TONE  = m_if.IN_TONE;
    assign l_if.IN_DUR   = m_if.IN_DUR;
    assign l_if.ABORT    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int t, input int c);
        exp_t e;
        e.len  = unit_tbl[c] * U;
        e.tone = e.len > 0 ? t : 0;
        e.dur  = e.len > 0 ? c : 0;
        return e;
    endfunction

    function automatic int cnt_ne(input int a[100], input int lo, input int hi, input int v);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (a[i] != v) n++;
        return n;
    endfunction

    task automatic idle(input int n);
        m_if.IN_VALID = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int t, input int c);
        bit r;
        bit ok = 1'b0;
        m_if.IN_VALID = 1'b1;
        m_if.IN_TONE  = 4'(t);
        m_if.IN_DUR   = 4'(c);
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            r = m_if.IN_READY;
            @(posedge clk);
            if (r) begin
                ok = 1'b1;
                exp_q.push_back(mk(t, c));
            end
            #1;
        end
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_done(input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            ok = m_if.NOTE_DONE;
        end
        chk("done_seen", 32'(ok), 1);
    endtask

    task automatic drain();
        m_if.IN_VALID = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!m_if.BUSY && exp_q.size() == 0) break;
        end
        chk("drain_busy", 32'(m_if.BUSY), 0);
        chk("drain_queue", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // monitor: each NOTE_DONE closes one note; compare what was heard against the model
    initial begin
        int len;
        int ct;
        int cd;
        exp_t e;
        len = 0;
        ct = 0;
        cd = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                len = 0;
                ct = 0;
                cd = 0;
            end else begin
                if (m_if.NOTE_DONE) begin
                    if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("note_tone", ct, e.tone);
                        chk("note_dur", cd, e.dur);
                        chk("note_len", len, e.len);
                    end
                    len = 0;
                    ct = 0;
                    cd = 0;
                end
                if (m_if.DURATION != 4'd0) begin
                    len++;
                    ct = int'(m_if.TONE);
                    cd = int'(m_if.DURATION);
                end
                if (m_if.ABORT) begin
                    len = 0;
                    ct = 0;
                    cd = 0;
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m_if.IN_VALID = 1'b0;
        m_if.IN_TONE  = '0;
        m_if.IN_DUR   = '0;
        m_if.ABORT    = 1'b0;
        #2;
        chk("rst_tone", 32'(m_if.TONE), 0);
        chk("rst_dur", 32'(m_if.DURATION), 0);
        chk("rst_busy", 32'(m_if.BUSY), 0);
        chk("rst_done", 32'(m_if.NOTE_DONE), 0);
        chk("rst_count", 32'(m_if.COUNT), 0);
        chk("rst_ready", 32'(m_if.IN_READY), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // single note: 80 cycles of tone 5, then 3 silent gap cycles
        push(5, 2);
        idle(0);
        @(negedge clk);
        chk("prepop_tone", 32'(m_if.TONE), 0);
        chk("prepop_count", 32'(m_if.COUNT), 1);
        @(negedge clk);
        chk("first_tone", 32'(m_if.TONE), 5);
        chk("first_dur", 32'(m_if.DURATION), 2);
        wait_done(200);
        chk("gap0_busy", 32'(m_if.BUSY), 1);
        repeat (2) @(negedge clk);
        chk("gap2_busy", 32'(m_if.BUSY), 1);
        chk("gap2_tone", 32'(m_if.TONE), 0);
        @(negedge clk);
        chk("after_gap_busy", 32'(m_if.BUSY), 0);
        @(posedge clk);
        #1;

        // code A then code 8, against both the gapped and the legato instance
        leg_en = 1'b1;
        push(9, 10);
        push(6, 8);
        idle(0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            md[i] = int'(m_if.DURATION);
            ld[i] = int'(l_if.DURATION);
            lt[i] = int'(l_if.TONE);
        end
        leg_en = 1'b0;
        chk("gap_noteA", cnt_ne(md, 0, 69, 10), 0);
        chk("gap_silent", cnt_ne(md, 70, 72, 0), 0);
        chk("gap_note8", cnt_ne(md, 73, 82, 8), 0);
        chk("gap_end", cnt_ne(md, 83, 83, 0), 0);
        chk("leg_noteA", cnt_ne(ld, 0, 69, 10), 0);
        chk("leg_note8", cnt_ne(ld, 70, 79, 8), 0);
        chk("leg_end", cnt_ne(ld, 80, 80, 0), 0);
        chk("leg_tone2", lt[70], 6);
        @(posedge clk);
        #1;
        drain();

        // six back-to-back pushes fill a 4-deep queue
        push(1, 8);
        push(2, 8);
        push(3, 9);
        push(4, 8);
        push(5, 8);
        chk("full_count", 32'(m_if.COUNT), 4);
        chk("full_ready", 32'(m_if.IN_READY), 0);
        push(6, 8);
        drain();

        // abort 30 cycles into a code-4 note with two notes queued
        push(3, 4);
        push(4, 8);
        push(6, 9);
        idle(28);
        m_if.ABORT    = 1'b1;
        m_if.IN_VALID = 1'b1;
        m_if.IN_TONE  = 4'd9;
        m_if.IN_DUR   = 4'd8;
        @(negedge clk);
        chk("abort_ready", 32'(m_if.IN_READY), 0);
        chk("abort_pre_tone", 32'(m_if.TONE), 3);
        @(posedge clk);
        exp_q.delete();
        #1;
        m_if.ABORT    = 1'b0;
        m_if.IN_VALID = 1'b0;
        @(negedge clk);
        chk("abort_tone", 32'(m_if.TONE), 0);
        chk("abort_dur", 32'(m_if.DURATION), 0);
        chk("abort_count", 32'(m_if.COUNT), 0);
        chk("abort_done", 32'(m_if.NOTE_DONE), 0);
        chk("abort_busy", 32'(m_if.BUSY), 0);
        repeat (30) @(negedge clk);
        chk("abort_stays_idle", 32'(m_if.BUSY), 0);
        @(posedge clk);
        #1;

        // zero-length note
        push(7, 0);
        idle(0);
        @(negedge clk);
        chk("zero_predone", 32'(m_if.NOTE_DONE), 0);
        @(negedge clk);
        chk("zero_done", 32'(m_if.NOTE_DONE), 1);
        chk("zero_tone", 32'(m_if.TONE), 0);
        @(negedge clk);
        chk("zero_busy", 32'(m_if.BUSY), 0);
        chk("zero_done_once", 32'(m_if.NOTE_DONE), 0);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of a note
        push(2, 3);
        push(8, 8);
        idle(15);
        #3 rst = 1'b1;
        #1;
        chk("arst_tone", 32'(m_if.TONE), 0);
        chk("arst_dur", 32'(m_if.DURATION), 0);
        chk("arst_busy", 32'(m_if.BUSY), 0);
        chk("arst_count", 32'(m_if.COUNT), 0);
        chk("arst_ready", 32'(m_if.IN_READY), 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // randomized stream
        for (int n = 0; n < 25; n++) begin
            push($urandom_range(0, 15), $urandom_range(0, 15));
            idle($urandom_range(0, 3));
        end
        drain();

        chk("final_queue", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
